// File: rtl/cdc_bus_launch.sv
// ---------------------------------------------------------------------------
// cdc_bus_launch
//
// Source-domain launcher for a multi-bit bus-enable clock-domain crossing.
// A word is taken from a valid/ready interface and held stable on
// unsync_bus. bus_enable then runs a 4-phase req/ack handshake with the
// destination domain. The destination returns its synchronized copy of
// bus_enable as ack_async, and that signal is resynchronized here.
//
// Optional feature (macro CDC_LAUNCH_TIMEOUT_EN):
//   When the macro is defined, a watchdog aborts a handshake that sits in
//   REQ or RELEASE for TIMEOUT cycles. An abort drops bus_enable, returns
//   the FSM to IDLE without a done_pulse, and pulses timeout_err for one
//   cycle. When the macro is undefined, the FSM waits indefinitely.
//
// Parameters:
//   D_WIDTH  width of the crossing data word
//   STAGES   synchronizer depth on ack_async (>= 2)
//   TIMEOUT  watchdog limit in source cycles (used only with the macro)
//
// Ports:
//   CLK          source-domain clock
//   RST          asynchronous active-low reset
//   in_valid     source has a word to send
//   in_data      word to send (sampled only on accept)
//   in_ready     launcher can accept a word this cycle
//   unsync_bus   registered data toward the destination synchronizer
//   bus_enable   request level toward the destination
//   ack_async    acknowledge level from the destination domain
//   done_pulse   one-cycle pulse when a transfer completes
//   busy         FSM is not in IDLE
//   timeout_err  one-cycle abort pulse (only with CDC_LAUNCH_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module cdc_bus_launch #(
    parameter int D_WIDTH = 8,
    parameter int STAGES  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic [D_WIDTH-1:0] unsync_bus,
    output logic               bus_enable,
    input  logic               ack_async,
    output logic               done_pulse,
`ifdef CDC_LAUNCH_TIMEOUT_EN
    output logic               busy,
    output logic               timeout_err
`else
    output logic               busy
`endif
);

    // Reject parameter values that cannot work when the design is elaborated.
    if (STAGES < 2) begin : g_bad_stages
        $error("cdc_bus_launch: STAGES must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cdc_bus_launch: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic [STAGES-1:0] ack_sr;
    logic              ack_sync;

    // ack_async reaches the rest of the design only through this chain.
    // NOTE: the synchronizer flops are reset with the rest of the design, so
    // a stale acknowledge cannot leak through after reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_sr <= '0;
        end else begin
            ack_sr <= {ack_sr[STAGES-2:0], ack_async};
        end
    end

    assign ack_sync = ack_sr[STAGES-1];

    // RST appears in this term so that in_ready is low while reset is held,
    // even though the state register then reads IDLE.
    assign in_ready = RST && (state == IDLE) && !ack_sync;
    assign busy     = (state != IDLE);

`ifdef CDC_LAUNCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    // The counter equals TIMEOUT-1 in the cycle before it would reach
    // TIMEOUT. Aborting on that edge drops bus_enable exactly TIMEOUT
    // cycles after the state was entered.
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] wd_cnt;
`endif

    // NOTE: state and all registered outputs use non-blocking assignments so
    // that every branch sees pre-edge values, regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            done_pulse <= 1'b0;
`ifdef CDC_LAUNCH_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            // Pulses default low and are raised only on their event edge.
            done_pulse <= 1'b0;
`ifdef CDC_LAUNCH_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        unsync_bus <= in_data;
                        state      <= SETUP;
                    end
                end
                // Data has been stable for one cycle before the request rises.
                SETUP: begin
                    bus_enable <= 1'b1;
                    state      <= REQ;
`ifdef CDC_LAUNCH_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                end
                REQ: begin
                    if (ack_sync) begin
                        bus_enable <= 1'b0;
                        state      <= RELEASE;
`ifdef CDC_LAUNCH_TIMEOUT_EN
                        wd_cnt     <= '0;
                    end else if (wd_cnt == T_LAST) begin
                        bus_enable  <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    if (!ack_sync) begin
                        done_pulse <= 1'b1;
                        state      <= IDLE;
`ifdef CDC_LAUNCH_TIMEOUT_EN
                    end else if (wd_cnt == T_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_bus_launch.sv
// ---------------------------------------------------------------------------
// tb_cdc_bus_launch
//
// Self-checking bench for cdc_bus_launch (D_WIDTH=8, STAGES=2). Inputs are
// driven and outputs are sampled on the falling clock edge. The bench plays
// the destination domain by returning ack_async with fixed delays. Each word
// is pushed to a scoreboard when it is offered and popped at done_pulse.
// When CDC_LAUNCH_TIMEOUT_EN is defined, the bench uses TIMEOUT=8 and also
// exercises the watchdog.
// ---------------------------------------------------------------------------
module tb_cdc_bus_launch;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] unsync_bus;
    logic          bus_enable;
    logic          ack_async;
    logic          done_pulse;
    logic          busy;
`ifdef CDC_LAUNCH_TIMEOUT_EN
    logic          timeout_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    cdc_bus_launch #(
        .D_WIDTH (DW),
        .STAGES  (2),
        .TIMEOUT (8)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .ack_async  (ack_async),
        .done_pulse (done_pulse),
`ifdef CDC_LAUNCH_TIMEOUT_EN
        .busy       (busy),
        .timeout_err(timeout_err)
`else
        .busy       (busy)
`endif
    );

    // Packed view of the outputs: {in_ready, busy, bus_enable, done_pulse, unsync_bus}.
    function automatic logic [DW+3:0] obs();
        return {in_ready, busy, bus_enable, done_pulse, unsync_bus};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Destination-side handshake. Entry is at the negedge right after
    // bus_enable rose. The task checks each phase against word d and pops the
    // scoreboard at done_pulse.
    task automatic respond(input logic [DW-1:0] d);
        logic [DW-1:0] e;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs() !== {4'b0110, d}) begin
                miscompares++;
                $display("FAIL req_hold: got %h exp %h", obs(), {4'b0110, d});
            end
            tick();
        end
        ack_async = 1'b1;
        // Two synchronizer edges, then the FSM edge that drops bus_enable.
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs() !== {4'b0110, d}) begin
                miscompares++;
                $display("FAIL ack_sync_wait: got %h exp %h", obs(), {4'b0110, d});
            end
        end
        tick();
        vectors++;
        if (obs() !== {4'b0100, d}) begin
            miscompares++;
            $display("FAIL be_fall: got %h exp %h", obs(), {4'b0100, d});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs() !== {4'b0100, d}) begin
                miscompares++;
                $display("FAIL release_hold: got %h exp %h", obs(), {4'b0100, d});
            end
        end
        ack_async = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs() !== {4'b0100, d}) begin
                miscompares++;
                $display("FAIL release_wait: got %h exp %h", obs(), {4'b0100, d});
            end
        end
        tick();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~d;
        vectors++;
        if (obs() !== {4'b1001, e}) begin
            miscompares++;
            $display("FAIL done: got %h exp %h", obs(), {4'b1001, e});
        end
        tick();
        vectors++;
        if (done_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL done_single: got %b exp 0", done_pulse);
        end
    endtask

    // Offer one word from IDLE and run its handshake to completion.
    task automatic send(input logic [DW-1:0] d);
        vectors++;
        if ({in_ready, busy, bus_enable, done_pulse} !== 4'b1000) begin
            miscompares++;
            $display("FAIL idle_ready: got %b exp 1000", {in_ready, busy, bus_enable, done_pulse});
        end
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        // SETUP: data is already out, request not yet raised.
        vectors++;
        if (obs() !== {4'b0100, d}) begin
            miscompares++;
            $display("FAIL setup: got %h exp %h", obs(), {4'b0100, d});
        end
        tick();
        respond(d);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        ack_async = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs() !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_state: got %h exp 000", obs());
            end
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (obs() !== 12'h800) begin
            miscompares++;
            $display("FAIL after_reset: got %h exp 800", obs());
        end
    endtask

    task automatic test_single();
        send(8'hA5);
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        in_data  = 8'h11;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        tick();
        vectors++;
        if (obs() !== {4'b0100, 8'h11}) begin
            miscompares++;
            $display("FAIL b2b_setup1: got %h exp %h", obs(), {4'b0100, 8'h11});
        end
        in_data = 8'h22;     // Must be ignored until the first transfer completes.
        tick();
        respond(8'h11);
        // in_valid was still high in the done cycle, so the second word is accepted.
        vectors++;
        if (obs() !== {4'b0100, 8'h22}) begin
            miscompares++;
            $display("FAIL b2b_setup2: got %h exp %h", obs(), {4'b0100, 8'h22});
        end
        in_valid = 1'b0;
        tick();
        respond(8'h22);
    endtask

    task automatic test_stale_ack();
        ack_async = 1'b1;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({in_ready, busy, bus_enable} !== 3'b000) begin
                miscompares++;
                $display("FAIL stale_no_accept: got %b exp 000", {in_ready, busy, bus_enable});
            end
        end
        ack_async = 1'b0;
        tick();
        vectors++;
        if ({in_ready, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL stale_clearing: got %b exp 00", {in_ready, busy});
        end
        tick();
        vectors++;
        if ({in_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL stale_cleared: got %b exp 10", {in_ready, busy});
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (obs() !== {4'b0100, 8'h5A}) begin
            miscompares++;
            $display("FAIL stale_accept: got %h exp %h", obs(), {4'b0100, 8'h5A});
        end
        tick();
        respond(8'h5A);
    endtask

    task automatic test_reset_mid_req();
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (bus_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_req_enable: got %b exp 1", bus_enable);
        end
        tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== 12'h000) begin
            miscompares++;
            $display("FAIL async_reset: got %h exp 000", obs());
        end
        tick();
        vectors++;
        if (obs() !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_no_done: got %h exp 000", obs());
        end
        rst_n = 1'b1;
        tick();
        send(8'h3C);
    endtask

`ifdef CDC_LAUNCH_TIMEOUT_EN
    task automatic test_timeout();
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        in_valid = 1'b0;
        tick();
        // bus_enable rose 5 time units ago, on the edge that entered REQ.
        for (int j = 1; j <= 8; j++) begin
            tick();
            vectors++;
            if (j < 8 && {bus_enable, timeout_err, done_pulse} !== 3'b100) begin
                miscompares++;
                $display("FAIL timeout_wait: cycle %0d got %b exp 100", j, {bus_enable, timeout_err, done_pulse});
            end else if (j == 8 && {bus_enable, timeout_err, done_pulse, busy, unsync_bus} !== {4'b0100, 8'h99}) begin
                miscompares++;
                $display("FAIL timeout_abort: got %h exp %h",
                         {bus_enable, timeout_err, done_pulse, busy, unsync_bus}, {4'b0100, 8'h99});
            end
        end
        tick();
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_single: got %b exp 0", timeout_err);
        end
        send(8'h42);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stale_ack();
        test_reset_mid_req();
`ifdef CDC_LAUNCH_TIMEOUT_EN
        test_timeout();
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cdc_bus_launch.md
Name: cdc_bus_launch

Overview:
- Source-domain launcher for the multi-bit bus-enable CDC scheme; the transmit end of the destination-side data synchronizer.
- Captures a word from a local valid/ready interface and holds it stable on unsync_bus.
- Drives bus_enable with a 4-phase req/ack handshake, using an acknowledge returned from the destination domain and resynchronized locally.
- Sits in the source clock domain wherever a register or config word crosses to another clock (e.g. reg file to UART/ALU domain).

Parameters:
- D_WIDTH, 8, width of the data word crossing the boundary.
- STAGES, 2, number of synchronizer flops on ack_async (minimum 2).
- TIMEOUT, 255, source cycles to wait in REQ or RELEASE before abort (used only with CDC_LAUNCH_TIMEOUT_EN).

Ports:
- CLK  input  1  source-domain clock.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  source has a word to send.
- in_data  input  D_WIDTH  word to send.
- in_ready  output  1  launcher can accept a word this cycle.
- unsync_bus  output  D_WIDTH  registered data toward the destination synchronizer; stable while bus_enable is high.
- bus_enable  output  1  request level toward the destination synchronizer.
- ack_async  input  1  acknowledge level from the destination domain (the destination's synchronized copy of bus_enable).
- done_pulse  output  1  one-cycle pulse when a transfer completes.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (RST=0, async): FSM=IDLE, unsync_bus=0, bus_enable=0, done_pulse=0, busy=0, ack sync flops=0. in_ready evaluates to 0 while reset is asserted.
- ack_sync: MSB of a STAGES-deep shift register clocked by CLK, fed by ack_async. No other logic may use ack_async directly.
- in_ready = (state==IDLE) & ~ack_sync. Combinational, registered terms only.
- Accept occurs when in_valid & in_ready at a CLK edge.
  - unsync_bus <= in_data on that edge.
  - FSM -> SETUP.
  - in_data is ignored at all other times.
- SETUP, 1 cycle: bus_enable <= 1; FSM -> REQ. Data is therefore stable at least 1 source cycle before bus_enable rises.
- REQ: bus_enable held 1, unsync_bus held. When ack_sync==1: bus_enable <= 0; FSM -> RELEASE.
- RELEASE: bus_enable 0, unsync_bus still held. When ack_sync==0: done_pulse <= 1 for exactly one cycle; FSM -> IDLE.
- Latency: accept at edge k gives bus_enable=1 after edge k+1. Minimum accept-to-done is 2 + 2·(STAGES + destination round trip) cycles.
- busy=1 in SETUP, REQ and RELEASE.
- unsync_bus keeps its last value in IDLE; it changes only on accept.
- Boundary conditions:
  - in_valid held high continuously: one word per full handshake, never back-to-back within a transfer.
  - ack_sync high while in IDLE (stale or glitch): in_ready=0 until it clears; no accept.
  - ack_sync drops during REQ before ever rising: remain in REQ.
  - RST asserted mid-transfer: immediate return to the reset state; bus_enable drops asynchronously; no done_pulse.
  - ack_async toggling faster than the synchronizer: sampled level only; the FSM only advances on the required level.

Optional Feature:
- Macro CDC_LAUNCH_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to REQ and on entry to RELEASE, and increments each cycle in those states.
  - When it reaches TIMEOUT: bus_enable <= 0, unsync_bus held, FSM -> IDLE, no done_pulse.
  - An extra output port timeout_err (1 bit, reset 0) pulses for one cycle.
  - After an abort, in_ready still obeys the ~ack_sync term.
- Not defined: no counter, no timeout_err port; the FSM waits indefinitely in REQ/RELEASE.

Test Plan:
- Reset then idle: RST=0 for 3 cycles, release -> all outputs 0; in_ready=1 on the first cycle after release with ack_async=0.
- Single transfer, D_WIDTH=8: in_data=0xA5, in_valid pulse; bench returns ack_async 3 cycles after bus_enable rises and drops it 3 cycles after bus_enable falls -> unsync_bus=0xA5 one cycle before bus_enable=1; bus_enable falls 2 cycles after ack_async rises (STAGES=2); exactly one done_pulse; in_ready stays 0 throughout.
- Back-to-back: in_valid held high with data 0x11 then 0x22 -> two separate handshakes; unsync_bus changes 0x11 to 0x22 only after the first done_pulse; never while bus_enable=1.
- Stale ack: ack_async=1 while idle with in_valid=1 -> no accept and in_ready=0; ack_async->0 -> accept 2 cycles later.
- Reset mid-REQ: assert RST while bus_enable=1 -> bus_enable=0 and unsync_bus=0 immediately; no done_pulse; a clean transfer of 0x3C succeeds afterwards.
- Timeout (CDC_LAUNCH_TIMEOUT_EN, TIMEOUT=8): ack_async never asserted -> bus_enable drops and timeout_err pulses 8 cycles after REQ entry; no done_pulse; next accept works.
